// File: rtl/csr_access_sequencer.sv
// Zicsr initiator: reads a CSR, computes the CSRRW/RS/RC result, issues one write strobe and returns the old value.
// Optional write-acknowledge timeout is built when CSR_WRITE_TIMEOUT_EN is defined.
module csr_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func3,
  input  logic [11:0] req_csr_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rd_data,
  output logic        resp_illegal,
  output logic [11:0] csr_addr,
  output logic [2:0]  csr_func3,
  output logic [4:0]  csr_imm,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        csr_write_enable,
  input  logic        csr_write_done
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [11:0] addr_q;
  logic [2:0]  func3_q;
  logic [4:0]  imm_q;
  logic [31:0] rs1_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_q;
  logic        resp_q;
  logic        ill_q;
  logic        we_q;
`ifdef CSR_WRITE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  tmo_q;
`endif

  logic [31:0] operand_d;
  logic [31:0] new_d;
  logic        write_intent_d;

  always_comb begin
    operand_d = func3_q[2] ? {27'b0, imm_q} : rs1_q;
    case (func3_q[1:0])
      2'b01:   new_d = operand_d;
      2'b10:   new_d = csr_rdata | operand_d;
      default: new_d = csr_rdata & ~operand_d;
    endcase
    write_intent_d = (func3_q[1:0] == 2'b01) || (imm_q != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      func3_q <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      resp_q  <= 1'b0;
      ill_q   <= 1'b0;
      we_q    <= 1'b0;
`ifdef CSR_WRITE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      resp_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_csr_addr;
          func3_q <= req_func3;
          imm_q   <= req_rs1_idx;
          rs1_q   <= req_rs1_data;
          if (req_func3[1:0] == 2'b00) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            ill_q   <= 1'b1;
            rd_q    <= '0;
          end else begin
            state_q <= S_READ;
          end
        end
        S_READ: begin
          // rd_q doubles as the saved old value for the write path
          rd_q <= csr_rdata;
          if (!write_intent_d) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            ill_q   <= 1'b0;
          end else if (addr_q[11:10] == 2'b11) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            ill_q   <= 1'b1;
          end else begin
            wdata_q <= new_d;
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          state_q <= S_WAIT;
`ifdef CSR_WRITE_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_WAIT: begin
          if (csr_write_done) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            ill_q   <= 1'b0;
          end
`ifdef CSR_WRITE_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            ill_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign resp_valid       = resp_q;
  assign resp_rd_data     = rd_q;
  assign resp_illegal     = ill_q;
  assign csr_addr         = addr_q;
  assign csr_func3        = func3_q;
  assign csr_imm          = imm_q;
  assign csr_wdata        = wdata_q;
  // Strobe is cut in the cycle reset rises so an aborted write never lands.
  assign csr_write_enable = we_q & ~rst;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Randomized bench for csr_access_sequencer with a transaction-level expectation model and a CSR-unit responder.
module tb_csr_access_sequencer;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rd_data;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [2:0]  csr_func3;
  logic [4:0]  csr_imm;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_write_enable;
  logic        csr_write_done;

  int n_cmp = 0;
  int n_bad = 0;
  int dly_cfg = 1;
  logic [7:0] dctr;

  always #5 clk = ~clk;

  csr_access_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_func3(req_func3), .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx),
    .req_rs1_data(req_rs1_data), .busy(busy), .resp_valid(resp_valid),
    .resp_rd_data(resp_rd_data), .resp_illegal(resp_illegal), .csr_addr(csr_addr),
    .csr_func3(csr_func3), .csr_imm(csr_imm), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_write_enable(csr_write_enable),
    .csr_write_done(csr_write_done)
  );

  // CSR unit: acknowledges dly_cfg cycles after seeing the strobe; 0 = never
  always @(posedge clk) begin
    if (rst) dctr <= '0;
    else if (csr_write_enable && dly_cfg > 0) dctr <= 8'(dly_cfg);
    else if (dctr != 0) dctr <= dctr - 8'd1;
  end
  assign csr_write_done = (dctr == 8'd1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Runs one instruction from accept to the cycle after its response.
  task automatic txn(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                     input logic [31:0] d, input logic [31:0] old, input int dly, input bit hold);
    logic [31:0] opnd, e_rd, e_wd, we_d, rd_s;
    bit e_ill, e_we, il_s;
    int e_resp, lim, we_n, we_c, rs_n, rs_c, rdy_bad, addr_bad;
    logic post_rdy, post_rv;
    e_we = 0; e_wd = '0; e_rd = old; e_ill = 0;
    opnd = f3[2] ? {27'd0, idx} : d;
    if (f3[1:0] == 2'b00) begin
      e_resp = 1; e_ill = 1; e_rd = '0;
    end else if (!(f3[1:0] == 2'b01 || idx != 0)) begin
      e_resp = 2;
    end else if (a[11:10] == 2'b11) begin
      e_resp = 2; e_ill = 1;
    end else begin
      e_we = 1;
      e_wd = (f3[1:0] == 2'b01) ? opnd : (f3[1:0] == 2'b10) ? (old | opnd) : (old & ~opnd);
      if (dly > 0) e_resp = 3 + dly;
`ifdef CSR_WRITE_TIMEOUT_EN
      else begin e_resp = 3 + TMO; e_ill = 1; end
`else
      else e_resp = -1;
`endif
    end
    @(negedge clk);
    req_func3 = f3; req_csr_addr = a; req_rs1_idx = idx; req_rs1_data = d;
    csr_rdata = old; dly_cfg = dly; req_valid = 1'b1;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lim = (e_resp < 0) ? 60 : e_resp + 1;
    we_n = 0; we_c = 0; we_d = '0; rs_n = 0; rs_c = 0; rd_s = '0; il_s = 0;
    rdy_bad = 0; addr_bad = 0; post_rdy = 1'b0; post_rv = 1'b1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (rs_n > 0 && k == rs_c + 1) begin
        post_rdy = req_ready; post_rv = resp_valid;
        break;
      end
      if (csr_write_enable) begin we_n++; we_c = k; we_d = csr_wdata; end
      if (resp_valid) begin rs_n++; rs_c = k; rd_s = resp_rd_data; il_s = resp_illegal; end
      if (req_ready) rdy_bad++;
      if (csr_addr !== a || csr_imm !== idx || csr_func3 !== f3) addr_bad++;
    end
    chk("strobe_count", we_n, {31'd0, e_we});
    if (e_we) begin
      chk("strobe_cycle", we_c, 32'd2);
      chk("wdata", we_d, e_wd);
    end
    chk("ready_low_while_busy", rdy_bad, 0);
    chk("csr_fields_stable", addr_bad, 0);
    if (e_resp >= 0) begin
      chk("resp_count", rs_n, 1);
      chk("resp_cycle", rs_c, e_resp);
      chk("rd_data", rd_s, e_rd);
      chk("illegal", {31'd0, il_s}, {31'd0, e_ill});
      chk("resp_one_cycle", {31'd0, post_rv}, 32'd0);
      chk("ready_after_resp", {31'd0, post_rdy}, 32'd1);
    end else begin
      chk("no_resp_no_timeout", rs_n, 0);
      chk("busy_held", {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [11:0] ra;
    logic [4:0]  ridx;
    int          rdly;
    int          seen;
    rst = 1'b1; req_valid = 1'b0; req_func3 = '0; req_csr_addr = '0;
    req_rs1_idx = '0; req_rs1_data = '0; csr_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_illegal", {31'd0, resp_illegal}, 32'd0);
    chk("rst_we", {31'd0, csr_write_enable}, 32'd0);
    chk("rst_rd", resp_rd_data, 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    chk("rst_addr", {20'd0, csr_addr}, 32'd0);
    chk("rst_func3_imm", {24'd0, csr_func3, csr_imm}, 32'd0);

    txn(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 32'h0, 1, 0);
    txn(3'b010, 12'hC00, 5'd0, 32'h1234_5678, 32'h12, 1, 0);
    txn(3'b111, 12'h300, 5'b00101, 32'hFFFF_FFFF, 32'h0000_000F, 1, 0);
    txn(3'b001, 12'hC00, 5'd3, 32'h1, 32'h55, 1, 0);
    txn(3'b000, 12'h340, 5'd7, 32'h1, 32'h99, 1, 0);
    txn(3'b100, 12'h340, 5'd7, 32'h1, 32'h99, 1, 0);
    txn(3'b110, 12'h305, 5'b11111, 32'h0, 32'h8000_0000, 2, 0);
    txn(3'b011, 12'h341, 5'd4, 32'h0000_FFFF, 32'hFFFF_FFFF, 3, 0);

    // Held req_valid: one accept, then re-accept on the edge after RESP
    txn(3'b001, 12'h340, 5'd2, 32'hA5A5_0000, 32'h1, 1, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_reaccept", {31'd0, busy}, 32'd1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (req_ready) seen = 1;
    end
    chk("hold_second_done", seen, 1);

    // Acknowledge never returns
    txn(3'b001, 12'h340, 5'd1, 32'h77, 32'h66, 0, 0);
`ifndef CSR_WRITE_TIMEOUT_EN
    do_reset();
`endif

    // Reset during WAIT
    @(negedge clk);
    req_func3 = 3'b001; req_csr_addr = 12'h340; req_rs1_idx = 5'd1;
    req_rs1_data = 32'h1; csr_rdata = 32'h2; dly_cfg = 0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_wait_idle", {30'd0, busy, req_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rst_wait_no_resp", seen, 0);

    // Reset rising in the strobe cycle suppresses the strobe immediately
    @(negedge clk);
    req_func3 = 3'b001; req_csr_addr = 12'h340; dly_cfg = 1; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_drops_strobe", {31'd0, csr_write_enable}, 32'd0);
    @(negedge clk); rst = 1'b0;
    chk("rst_strobe_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rf3  = 3'($urandom);
      ra   = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      ridx = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      rdly = $urandom_range(1, 4);
      txn(rf3, ra, ridx, $urandom, $urandom, rdly, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
